// File: rtl/conv_main_fsm.sv
// conv_main_fsm: layer sequencer for the RepVGG conv accelerator.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   start           : START register, bit 0 launches one layer
//   in_addr, w3_addr, w1_addr, out_addr : byte base addresses
//   mapsize, ich, och : square map side, input and output channels
//   conv_finish     : one-cycle layer-complete pulse
//   busy            : high from launch through the conv_finish cycle
//   dma_req/op/addr/len, dma_done : DMA transfer handshake
//   pe_start/row/och, pe_done     : PE array row handshake
// Every output is a flop loaded from the next-state view, so each
// output already reflects the state the FSM is entering.
module conv_main_fsm #(
    parameter int OCH_TILE = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] start,
    input  logic [31:0] in_addr,
    input  logic [31:0] w3_addr,
    input  logic [31:0] w1_addr,
    input  logic [31:0] out_addr,
    input  logic [31:0] mapsize,
    input  logic [31:0] ich,
    input  logic [31:0] och,
    output logic        conv_finish,
    output logic        busy,
    output logic        dma_req,
    output logic [1:0]  dma_op,
    output logic [31:0] dma_addr,
    output logic [31:0] dma_len,
    input  logic        dma_done,
    output logic        pe_start,
    output logic [15:0] pe_row,
    output logic [7:0]  pe_och,
    input  logic        pe_done
);

    localparam int          TILE_SHIFT = $clog2(OCH_TILE);
    localparam logic [31:0] TILE       = 32'(OCH_TILE);

    typedef enum logic [3:0] {
        IDLE,
        SETUP,
        LD_W3,
        LD_W1,
        LD_IN,
        COMP,
        ST_OUT,
        NEXT,
        FIN
    } state_t;

    state_t state;
    state_t state_d;

    // latched configuration
    logic [31:0] in_base;
    logic [31:0] w3_base;
    logic [31:0] w1_base;
    logic [31:0] out_base;
    logic [31:0] ms;
    logic [31:0] ich_r;
    logic [31:0] och_r;
    logic [31:0] in_base_d;
    logic [31:0] w3_base_d;
    logic [31:0] w1_base_d;
    logic [31:0] out_base_d;
    logic [31:0] ms_d;
    logic [31:0] ich_r_d;
    logic [31:0] och_r_d;

    // derived values and walking pointers
    logic [31:0] row_in;
    logic [31:0] ntile;
    logic [31:0] w3_ptr;
    logic [31:0] w1_ptr;
    logic [31:0] in_ptr;
    logic [31:0] out_ptr;
    logic [31:0] tile;
    logic [31:0] row;
    logic [31:0] row_in_d;
    logic [31:0] ntile_d;
    logic [31:0] w3_ptr_d;
    logic [31:0] w1_ptr_d;
    logic [31:0] in_ptr_d;
    logic [31:0] out_ptr_d;
    logic [31:0] tile_d;
    logic [31:0] row_d;

    // next values of the registered outputs
    logic        conv_finish_d;
    logic        busy_d;
    logic        dma_req_d;
    logic [1:0]  dma_op_d;
    logic [31:0] dma_addr_d;
    logic [31:0] dma_len_d;
    logic        pe_start_d;
    logic [15:0] pe_row_d;
    logic [7:0]  pe_och_d;

    logic [32:0] och_round;
    logic [32:0] ntile_wide;
    logic [31:0] och_left;
    logic [31:0] tile_och;
    logic [31:0] och_left_n;
    logic [31:0] tile_och_n;
    logic [31:0] row_inc;
    logic [31:0] tile_inc;
    logic        unused_bits;

    // ceil(och / OCH_TILE) without losing the carry of the rounding add
    assign och_round  = {1'b0, och_r} + {1'b0, TILE - 32'd1};
    assign ntile_wide = och_round >> TILE_SHIFT;

    // channels in the tile currently being worked on
    assign och_left = och_r - (tile << TILE_SHIFT);
    assign tile_och = (och_left < TILE) ? och_left : TILE;

    assign row_inc  = row + 32'd1;
    assign tile_inc = tile + 32'd1;

    assign unused_bits = ^{start[31:1], ntile_wide[32]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            in_base     <= '0;
            w3_base     <= '0;
            w1_base     <= '0;
            out_base    <= '0;
            ms          <= '0;
            ich_r       <= '0;
            och_r       <= '0;
            row_in      <= '0;
            ntile       <= '0;
            w3_ptr      <= '0;
            w1_ptr      <= '0;
            in_ptr      <= '0;
            out_ptr     <= '0;
            tile        <= '0;
            row         <= '0;
            conv_finish <= 1'b0;
            busy        <= 1'b0;
            dma_req     <= 1'b0;
            dma_op      <= 2'd0;
            dma_addr    <= '0;
            dma_len     <= '0;
            pe_start    <= 1'b0;
            pe_row      <= '0;
            pe_och      <= '0;
        end else begin
            state       <= state_d;
            in_base     <= in_base_d;
            w3_base     <= w3_base_d;
            w1_base     <= w1_base_d;
            out_base    <= out_base_d;
            ms          <= ms_d;
            ich_r       <= ich_r_d;
            och_r       <= och_r_d;
            row_in      <= row_in_d;
            ntile       <= ntile_d;
            w3_ptr      <= w3_ptr_d;
            w1_ptr      <= w1_ptr_d;
            in_ptr      <= in_ptr_d;
            out_ptr     <= out_ptr_d;
            tile        <= tile_d;
            row         <= row_d;
            conv_finish <= conv_finish_d;
            busy        <= busy_d;
            dma_req     <= dma_req_d;
            dma_op      <= dma_op_d;
            dma_addr    <= dma_addr_d;
            dma_len     <= dma_len_d;
            pe_start    <= pe_start_d;
            pe_row      <= pe_row_d;
            pe_och      <= pe_och_d;
        end
    end

    always_comb begin
        state_d    = state;
        in_base_d  = in_base;
        w3_base_d  = w3_base;
        w1_base_d  = w1_base;
        out_base_d = out_base;
        ms_d       = ms;
        ich_r_d    = ich_r;
        och_r_d    = och_r;
        row_in_d   = row_in;
        ntile_d    = ntile;
        w3_ptr_d   = w3_ptr;
        w1_ptr_d   = w1_ptr;
        in_ptr_d   = in_ptr;
        out_ptr_d  = out_ptr;
        tile_d     = tile;
        row_d      = row;

        unique case (state)
            IDLE: begin
                if (start[0]) begin
                    in_base_d  = in_addr;
                    w3_base_d  = w3_addr;
                    w1_base_d  = w1_addr;
                    out_base_d = out_addr;
                    ms_d       = mapsize;
                    ich_r_d    = ich;
                    och_r_d    = och;
                    state_d    = SETUP;
                end
            end
            SETUP: begin
                row_in_d  = ms * ich_r;
                ntile_d   = ntile_wide[31:0];
                w3_ptr_d  = w3_base;
                w1_ptr_d  = w1_base;
                in_ptr_d  = in_base;
                out_ptr_d = out_base;
                tile_d    = '0;
                row_d     = '0;
                if (ms == '0 || ich_r == '0 || och_r == '0) begin
                    state_d = FIN;
                end else begin
                    state_d = LD_W3;
                end
            end
            LD_W3: begin
                if (dma_done) state_d = LD_W1;
            end
            LD_W1: begin
                if (dma_done) state_d = LD_IN;
            end
            LD_IN: begin
                if (dma_done) state_d = COMP;
            end
            COMP: begin
                if (pe_done) state_d = ST_OUT;
            end
            ST_OUT: begin
                if (dma_done) state_d = NEXT;
            end
            NEXT: begin
                out_ptr_d = out_ptr + ms * tile_och;
                if (row_inc < ms) begin
                    row_d    = row_inc;
                    in_ptr_d = in_ptr + row_in;
                    state_d  = LD_IN;
                end else begin
                    row_d    = '0;
                    in_ptr_d = in_base;
                    w3_ptr_d = w3_ptr + 32'd9 * ich_r * TILE;
                    w1_ptr_d = w1_ptr + ich_r * TILE;
                    tile_d   = tile_inc;
                    state_d  = (tile_inc < ntile) ? LD_W3 : FIN;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // channel count of the tile being entered, for lengths and pe_och
        och_left_n = och_r - (tile_d << TILE_SHIFT);
        tile_och_n = (och_left_n < TILE) ? och_left_n : TILE;

        busy_d        = (state_d != IDLE);
        conv_finish_d = (state_d == FIN);
        dma_req_d     = 1'b0;
        dma_op_d      = dma_op;
        dma_addr_d    = dma_addr;
        dma_len_d     = dma_len;

        unique case (state_d)
            LD_W3: begin
                dma_req_d  = 1'b1;
                dma_op_d   = 2'd0;
                dma_addr_d = w3_ptr_d;
                dma_len_d  = 32'd9 * (ich_r * tile_och_n);
            end
            LD_W1: begin
                dma_req_d  = 1'b1;
                dma_op_d   = 2'd1;
                dma_addr_d = w1_ptr_d;
                dma_len_d  = ich_r * tile_och_n;
            end
            LD_IN: begin
                dma_req_d  = 1'b1;
                dma_op_d   = 2'd2;
                dma_addr_d = in_ptr_d;
                dma_len_d  = row_in_d;
            end
            ST_OUT: begin
                dma_req_d  = 1'b1;
                dma_op_d   = 2'd3;
                dma_addr_d = out_ptr_d;
                dma_len_d  = ms * tile_och_n;
            end
            default: begin
                dma_req_d = 1'b0;
            end
        endcase

        // pe_start only on the cycle COMP is first entered
        pe_start_d = (state_d == COMP) && (state != COMP);
        pe_row_d   = pe_start_d ? row_d[15:0] : pe_row;
        pe_och_d   = (state_d inside {LD_W3, LD_W1, LD_IN, COMP, ST_OUT, NEXT})
                   ? tile_och_n[7:0] : 8'd0;
    end

endmodule

// File: tb/tb_conv_main_fsm.sv
// tb_conv_main_fsm: directed bench for conv_main_fsm with DMA/PE
// responders, a transfer log and a per-layer expected sequence.
module tb_conv_main_fsm;

    typedef logic [65:0] xfer_t;
    typedef logic [23:0] pe_t;

    logic        clk;
    logic        rst;
    logic [31:0] start;
    logic [31:0] in_addr;
    logic [31:0] w3_addr;
    logic [31:0] w1_addr;
    logic [31:0] out_addr;
    logic [31:0] mapsize;
    logic [31:0] ich;
    logic [31:0] och;
    logic        conv_finish;
    logic        busy;
    logic        dma_req;
    logic [1:0]  dma_op;
    logic [31:0] dma_addr;
    logic [31:0] dma_len;
    logic        dma_done;
    logic        pe_start;
    logic [15:0] pe_row;
    logic [7:0]  pe_och;
    logic        pe_done;

    logic dma_done_r;
    logic pe_done_r;
    logic sp_dma;
    logic sp_pe;

    int  tests;
    int  fails;
    int  fin_cnt;
    int  fin0;
    int  act_cnt;
    int  unstable;
    bit  rand_lat;
    int  dma_lat;
    int  pe_lat;

    xfer_t dma_log[$];
    xfer_t exp_dma[$];
    pe_t   pe_log[$];
    pe_t   exp_pe[$];

    assign dma_done = dma_done_r | sp_dma;
    assign pe_done  = pe_done_r | sp_pe;

    conv_main_fsm #(.OCH_TILE(8)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .in_addr(in_addr),
        .w3_addr(w3_addr),
        .w1_addr(w1_addr),
        .out_addr(out_addr),
        .mapsize(mapsize),
        .ich(ich),
        .och(och),
        .conv_finish(conv_finish),
        .busy(busy),
        .dma_req(dma_req),
        .dma_op(dma_op),
        .dma_addr(dma_addr),
        .dma_len(dma_len),
        .dma_done(dma_done),
        .pe_start(pe_start),
        .pe_row(pe_row),
        .pe_och(pe_och),
        .pe_done(pe_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // DMA responder
    initial begin : dma_resp
        bit    act;
        int    cnt;
        xfer_t cur;
        act = 1'b0;
        cnt = 0;
        cur = '0;
        dma_done_r = 1'b0;
        forever begin
            @(negedge clk);
            dma_done_r = 1'b0;
            if (rst) begin
                act = 1'b0;
            end else begin
                if (act) begin
                    if (!dma_req || {dma_op, dma_addr, dma_len} !== cur)
                        unstable++;
                end else if (dma_req) begin
                    act = 1'b1;
                    cur = {dma_op, dma_addr, dma_len};
                    cnt = rand_lat ? int'($urandom_range(0, 20)) : dma_lat;
                end
                if (act) begin
                    if (cnt == 0) begin
                        dma_done_r = 1'b1;
                        act = 1'b0;
                        dma_log.push_back(cur);
                    end else begin
                        cnt--;
                    end
                end
            end
        end
    end

    // PE responder
    initial begin : pe_resp
        bit act;
        int cnt;
        act = 1'b0;
        cnt = 0;
        pe_done_r = 1'b0;
        forever begin
            @(negedge clk);
            pe_done_r = 1'b0;
            if (rst) begin
                act = 1'b0;
            end else begin
                if (act) begin
                    if (pe_start) unstable++;
                end else if (pe_start) begin
                    act = 1'b1;
                    pe_log.push_back({pe_row, pe_och});
                    cnt = rand_lat ? int'($urandom_range(0, 20)) : pe_lat;
                end
                if (act) begin
                    if (cnt == 0) begin
                        pe_done_r = 1'b1;
                        act = 1'b0;
                    end else begin
                        cnt--;
                    end
                end
            end
        end
    end

    initial begin : mon
        forever begin
            @(negedge clk);
            if (conv_finish) fin_cnt++;
            if (dma_req || pe_start) act_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [71:0] obs,
                       input logic [71:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic xfer_t getd(input int i);
        return (i < dma_log.size()) ? dma_log[i] : 'x;
    endfunction

    function automatic pe_t getp(input int i);
        return (i < pe_log.size()) ? pe_log[i] : 'x;
    endfunction

    task automatic clear();
        dma_log.delete();
        pe_log.delete();
        unstable = 0;
        fin0 = fin_cnt;
    endtask

    // Expected transfer/row sequence for one layer with 8-channel tiles.
    task automatic build_exp(input logic [31:0] ms, ic, oc, ia, w3a, w1a, oa);
        logic [31:0] op;
        logic [31:0] left;
        logic [31:0] toch;
        exp_dma.delete();
        exp_pe.delete();
        op = oa;
        for (int t = 0; t * 8 < int'(oc); t++) begin
            left = oc - 32'(8 * t);
            toch = (left > 32'd8) ? 32'd8 : left;
            exp_dma.push_back({2'd0, w3a + 32'(72 * t) * ic, 32'd9 * ic * toch});
            exp_dma.push_back({2'd1, w1a + 32'(8 * t) * ic, ic * toch});
            for (int r = 0; r < int'(ms); r++) begin
                exp_dma.push_back({2'd2, ia + 32'(r) * ms * ic, ms * ic});
                exp_dma.push_back({2'd3, op, ms * toch});
                exp_pe.push_back({16'(r), toch[7:0]});
                op = op + ms * toch;
            end
        end
    endtask

    // Launch pulse; returns at the negedge of the SETUP cycle with the
    // config inputs scrambled so only the latched copy can be used.
    task automatic launch(input logic [31:0] ms, ic, oc, ia, w3a, w1a, oa);
        @(negedge clk);
        mapsize  = ms;
        ich      = ic;
        och      = oc;
        in_addr  = ia;
        w3_addr  = w3a;
        w1_addr  = w1a;
        out_addr = oa;
        start    = 32'h1;
        @(negedge clk);
        start    = 32'h0;
        mapsize  = 32'h0BAD_0005;
        ich      = 32'h0BAD_0003;
        och      = 32'h0BAD_0009;
        in_addr  = 32'hDEAD_0000;
        w3_addr  = 32'hDEAD_1000;
        w1_addr  = 32'hDEAD_2000;
        out_addr = 32'hDEAD_3000;
    endtask

    task automatic wait_fin(input string tag, input int max);
        int n;
        n = 0;
        while (conv_finish !== 1'b1 && n < max) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_timeout"}, 72'(n < max), 72'd1);
        @(negedge clk);
        chk({tag, "_finish_pulse"}, {conv_finish, busy}, 2'b00);
        repeat (2) @(negedge clk);
    endtask

    task automatic compare(input string tag);
        chk({tag, "_dma_count"}, dma_log.size(), exp_dma.size());
        foreach (exp_dma[i]) chk({tag, "_dma"}, getd(i), exp_dma[i]);
        chk({tag, "_pe_count"}, pe_log.size(), exp_pe.size());
        foreach (exp_pe[i]) chk({tag, "_pe"}, getp(i), exp_pe[i]);
        chk({tag, "_stable"}, unstable, 0);
        chk({tag, "_finish_count"}, fin_cnt - fin0, 1);
    endtask

    initial begin : main
        int  n;
        int  a0;
        int  f0;
        bit  did_d;
        bit  did_p;
        logic [31:0] dm [3];
        logic [31:0] di [3];
        logic [31:0] dc [3];

        tests = 0;
        fails = 0;
        fin_cnt = 0;
        act_cnt = 0;
        unstable = 0;
        rand_lat = 1'b0;
        dma_lat = 0;
        pe_lat = 0;
        sp_dma = 1'b0;
        sp_pe = 1'b0;
        rst = 1'b1;
        start = '0;
        mapsize = '0;
        ich = '0;
        och = '0;
        in_addr = '0;
        w3_addr = '0;
        w1_addr = '0;
        out_addr = '0;
        repeat (3) @(negedge clk);
        chk("reset_ctrl", {conv_finish, busy, dma_req, dma_op, pe_start,
                           pe_row, pe_och}, '0);
        chk("reset_dma", {dma_addr, dma_len}, '0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // single tile, zero-latency responders
        clear();
        build_exp(4, 3, 8, 32'h1000, 32'h2000, 32'h3000, 32'h4000);
        launch(4, 3, 8, 32'h1000, 32'h2000, 32'h3000, 32'h4000);
        chk("t1_setup", {busy, dma_req}, 2'b10);
        @(negedge clk);
        chk("t1_first_req", {dma_req, dma_op, dma_addr, dma_len},
            {1'b1, 2'd0, 32'h2000, 32'd216});
        wait_fin("t1", 2000);
        compare("t1");
        chk("t1_w3", getd(0), {2'd0, 32'h2000, 32'd216});
        chk("t1_w1", getd(1), {2'd1, 32'h3000, 32'd24});
        for (int r = 0; r < 4; r++) begin
            chk("t1_in", getd(2 + 2 * r), {2'd2, 32'(32'h1000 + 12 * r), 32'd12});
            chk("t1_out", getd(3 + 2 * r), {2'd3, 32'(32'h4000 + 32 * r), 32'd32});
        end

        // two tiles, partial second tile
        dma_lat = 1;
        pe_lat = 2;
        clear();
        build_exp(2, 1, 10, 32'h100, 32'h200, 32'h300, 32'h400);
        launch(2, 1, 10, 32'h100, 32'h200, 32'h300, 32'h400);
        wait_fin("t2", 2000);
        compare("t2");
        chk("t2_w3_t0", getd(0), {2'd0, 32'h200, 32'd72});
        chk("t2_w1_t0", getd(1), {2'd1, 32'h300, 32'd8});
        chk("t2_pe_t0", getp(0), {16'd0, 8'd8});
        chk("t2_w3_t1", getd(6), {2'd0, 32'h248, 32'd18});
        chk("t2_w1_t1", getd(7), {2'd1, 32'h308, 32'd2});
        chk("t2_in_restart", getd(8), {2'd2, 32'h100, 32'd2});
        chk("t2_pe_t1", getp(2), {16'd0, 8'd2});

        // degenerate configurations
        dm[0] = 4; di[0] = 3; dc[0] = 0;
        dm[1] = 0; di[1] = 3; dc[1] = 8;
        dm[2] = 4; di[2] = 0; dc[2] = 8;
        for (int k = 0; k < 3; k++) begin
            clear();
            a0 = act_cnt;
            launch(dm[k], di[k], dc[k], 32'h10, 32'h20, 32'h30, 32'h40);
            chk("deg_setup", {conv_finish, busy}, 2'b01);
            @(negedge clk);
            chk("deg_fin", {conv_finish, busy, dma_req, pe_start}, 4'b1100);
            @(negedge clk);
            chk("deg_idle", {conv_finish, busy}, 2'b00);
            chk("deg_activity", act_cnt - a0, 0);
            chk("deg_finish_count", fin_cnt - fin0, 1);
        end

        // relaunch attempt and spurious done pulses mid-layer
        dma_lat = 3;
        pe_lat = 3;
        clear();
        build_exp(3, 2, 8, 32'h5000, 32'h6000, 32'h7000, 32'h8000);
        launch(3, 2, 8, 32'h5000, 32'h6000, 32'h7000, 32'h8000);
        did_d = 1'b0;
        did_p = 1'b0;
        n = 0;
        while (conv_finish !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
            sp_dma = 1'b0;
            sp_pe = 1'b0;
            start = 32'h0;
            if (pe_start && !did_d) begin
                sp_dma = 1'b1;
                did_d = 1'b1;
            end
            if (dma_req && dma_op == 2'd2 && !did_p) begin
                sp_pe = 1'b1;
                did_p = 1'b1;
            end
            if (n == 25) begin
                start = 32'h1;
                chk("t4_busy_at_restart", busy, 1);
            end
        end
        sp_dma = 1'b0;
        sp_pe = 1'b0;
        start = 32'h0;
        chk("t4_timeout", 72'(n < 3000), 72'd1);
        chk("t4_injected", {did_d, did_p}, 2'b11);
        @(negedge clk);
        chk("t4_finish_pulse", {conv_finish, busy}, 2'b00);
        repeat (4) @(negedge clk);
        chk("t4_no_relaunch", busy, 0);
        compare("t4");

        // reset during ST_OUT
        dma_lat = 2;
        pe_lat = 1;
        clear();
        launch(2, 1, 4, 32'h900, 32'hA00, 32'hB00, 32'hC00);
        n = 0;
        while (!(dma_req === 1'b1 && dma_op === 2'd3) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("t5_reach_st_out", 72'(n < 500), 72'd1);
        f0 = fin_cnt;
        rst = 1'b1;
        @(negedge clk);
        chk("t5_rst_ctrl", {conv_finish, busy, dma_req, dma_op, pe_start,
                            pe_row, pe_och}, '0);
        chk("t5_rst_dma", {dma_addr, dma_len}, '0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("t5_no_finish", fin_cnt - f0, 0);
        chk("t5_idle", busy, 0);
        clear();
        build_exp(2, 1, 4, 32'h900, 32'hA00, 32'hB00, 32'hC00);
        launch(2, 1, 4, 32'h900, 32'hA00, 32'hB00, 32'hC00);
        wait_fin("t5b", 2000);
        compare("t5b");

        // random latencies, three tiles of seven rows
        rand_lat = 1'b1;
        clear();
        build_exp(7, 5, 17, 32'h10000, 32'h20000, 32'h30000, 32'h40000);
        launch(7, 5, 17, 32'h10000, 32'h20000, 32'h30000, 32'h40000);
        wait_fin("t6", 20000);
        compare("t6");
        chk("t6_rows", pe_log.size(), 21);
        chk("t6_w3_t1", getd(16), {2'd0, 32'h20168, 32'd360});
        chk("t6_w3_t2", getd(32), {2'd0, 32'h202D0, 32'd45});
        chk("t6_last_row", getp(20), {16'd6, 8'd1});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/conv_main_fsm.md
# conv_main_fsm

Top-level sequencer for the RepVGG conv accelerator. Sits directly downstream of the ICB register slave: it consumes the START strobe and the configuration registers (IN/W3/W1/OUT base addresses, MAPSIZE, ICH, OCH). It drives the DMA engine and the PE array through one convolution layer, tiled over output channels. At the end it returns the one-cycle `conv_finish` pulse that sets the slave's DONE register.

## Interface
- `OCH_TILE`, 8: output channels computed per pass (power of two, ≥1)
- `clk` in 1: single clock domain
- `rst` in 1: synchronous, active-high reset
- `start` in 32: START register; bit 0 high for one cycle = launch
- `in_addr`, `w3_addr`, `w1_addr`, `out_addr` in 32 each: byte base addresses
- `mapsize`, `ich`, `och` in 32 each: feature-map side (square), input channels, output channels
- `conv_finish` out 1: one-cycle pulse on layer completion
- `busy` out 1: high from accepted launch until the `conv_finish` cycle inclusive
- `dma_req` out 1: transfer request, level-held until `dma_done`
- `dma_op` out 2: 0 = load W3, 1 = load W1, 2 = load IN row, 3 = store OUT row
- `dma_addr` out 32: transfer start byte address
- `dma_len` out 32: transfer length in bytes
- `dma_done` in 1: one-cycle completion pulse from the DMA engine
- `pe_start` out 1: one-cycle pulse to start one output row
- `pe_row` out 16: index of the row being computed
- `pe_och` out 8: active output channels in the current tile (1..OCH_TILE)
- `pe_done` in 1: one-cycle row-complete pulse from the PE array

## Operation
- States: IDLE, SETUP, LD_W3, LD_W1, LD_IN, COMP, ST_OUT, NEXT, FIN.
- IDLE: on `start[0]`=1, latch all 7 config inputs into internal registers, go to SETUP. Config inputs are ignored at all other times.
- SETUP: compute the derived values, all 32-bit modulo 2^32:
  - row_in = MAPSIZE·ICH
  - ntile = ceil(OCH/OCH_TILE)
  - Pointers: w3_ptr = W3_ADDR, w1_ptr = W1_ADDR, in_ptr = IN_ADDR, out_ptr = OUT_ADDR
  - tile = 0, row = 0
  - If MAPSIZE, ICH or OCH = 0, go to FIN; otherwise go to LD_W3.
- tile_och = min(OCH_TILE, OCH − tile·OCH_TILE). It drives `pe_och` throughout the tile.
- LD_W3: `dma_op`=0, addr = w3_ptr, len = 9·ICH·tile_och.
- LD_W1: `dma_op`=1, addr = w1_ptr, len = ICH·tile_och.
- LD_IN: `dma_op`=2, addr = in_ptr, len = row_in.
- COMP: pulse `pe_start` on the entry cycle with `pe_row` = row, then wait for `pe_done`.
- ST_OUT: `dma_op`=3, addr = out_ptr, len = MAPSIZE·tile_och.
- Each DMA state holds `dma_req`=1 with op/addr/len stable. On `dma_done`, deassert `dma_req` and advance: LD_W3→LD_W1→LD_IN; ST_OUT→NEXT.
- COMP→ST_OUT on `pe_done`.
- NEXT (1 cycle):
  - out_ptr += MAPSIZE·tile_och, in_ptr += row_in, row += 1.
  - If row < MAPSIZE: go to LD_IN.
  - Else: row = 0, in_ptr = IN_ADDR, w3_ptr += 9·ICH·OCH_TILE, w1_ptr += ICH·OCH_TILE, tile += 1.
  - Then go to LD_W3 if tile < ntile, else FIN.
- FIN: `conv_finish`=1 for exactly one cycle, go to IDLE.
- `start[0]` while busy: ignored, no relaunch, no state change.
- `dma_done` outside DMA states and `pe_done` outside COMP: ignored.
- Reset mid-operation: immediate return to IDLE, all outputs to reset value, no `conv_finish`.

## Timing
- Reset values:
  - `dma_req`, `pe_start`, `conv_finish`, `busy` = 0
  - `dma_op` = 0, `dma_addr` = 0, `dma_len` = 0
  - `pe_row` = 0, `pe_och` = 0
  - All internal registers = 0
- All outputs are registered.
- `start[0]` seen at edge N → SETUP during N+1 → `dma_req` high during N+2 (first LD_W3 cycle).
- `dma_req` drops in the cycle after `dma_done` is sampled. A new request can assert in that same cycle, so there is no idle gap.
- `pe_start` is high only during the first cycle of COMP.
- `busy` rises in the SETUP cycle and falls the cycle after FIN.
- Degenerate config: `conv_finish` 2 cycles after launch (SETUP→FIN), no DMA or PE activity.
- Zero-latency responders (done the cycle after req/start): per row = LD_IN 2 + COMP 2 + ST_OUT 2 + NEXT 1 cycles.

## Test plan
- MAPSIZE=4, ICH=3, OCH=8, bases 0x1000/0x2000/0x3000/0x4000:
  - Expect 1 W3 load (0x2000, 216), 1 W1 load (0x3000, 24).
  - Expect 4 rows: IN 0x1000+12r len 12, OUT 0x4000+32r len 32.
  - Expect one `conv_finish`.
- OCH=10, MAPSIZE=2, ICH=1:
  - Tile 0: `pe_och`=8, W3 len 72 @W3_ADDR, W1 len 8.
  - Tile 1: `pe_och`=2, W3 len 18 @W3_ADDR+72, W1 len 2 @W1_ADDR+8.
  - IN pointer restarts at IN_ADDR for tile 1.
- OCH=0 (or MAPSIZE=0, or ICH=0): `conv_finish` exactly 2 cycles after `start[0]`; `dma_req` and `pe_start` never assert.
- Second `start[0]` pulse mid-layer, plus spurious `dma_done` in COMP and spurious `pe_done` in LD_IN: transfer sequence unchanged, exactly one `conv_finish`.
- Assert `rst` during ST_OUT:
  - Next cycle: all outputs 0, state IDLE.
  - A fresh launch then completes normally.
- Random 0–20-cycle `dma_done`/`pe_done` latencies, MAPSIZE=7, ICH=5, OCH=17:
  - Every op/addr/len stays stable while `dma_req` is high.
  - Total of 3 tiles × 7 rows.
